multicycle_ctrl: RTL and testbench

- Moore-style control FSM that sequences a shared-memory, multi-cycle MIPS datapath (single ALU, single memory port, IR/ALUOut registers).
- Issues per-state datapath selects and write strobes.
- Stalls on a req/ready memory handshake.
- Sits beside the ALU decoder: it supplies aluop, and the ALU decoder resolves funct/op into the ALU control.

---
 rtl/multicycle_ctrl_pkg.sv | 88 ++++++++
 rtl/multicycle_ctrl_outdec.sv | 124 ++++++++++++
 rtl/multicycle_ctrl.sv | 111 +++++++++++
 tb/tb_multicycle_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit.
//   - state encodings (also visible on the state_o debug port)
//   - opcode / funct constants for the supported instruction subset
//   - select codes for aluop, pcsrc and alusrcb
//   - ctrl_t: the complete control word produced by ctrl_outdec
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_RTEXE  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BEQ    = 4'd9,
    S_IMMEXE = 4'd10,
    S_IMMWB  = 4'd11,
    S_JUMP   = 4'd12,
    S_JR     = 4'd13
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] EXE_RTYPE_OP = 6'b000000;
  localparam logic [5:0] EXE_J_OP     = 6'b000010;
  localparam logic [5:0] EXE_BEQ_OP   = 6'b000100;
  localparam logic [5:0] EXE_ADDI_OP  = 6'b001000;
  localparam logic [5:0] EXE_ANDI_OP  = 6'b001100;
  localparam logic [5:0] EXE_ORI_OP   = 6'b001101;
  localparam logic [5:0] EXE_XORI_OP  = 6'b001110;
  localparam logic [5:0] EXE_LUI_OP   = 6'b001111;
  localparam logic [5:0] EXE_LW_OP    = 6'b100011;
  localparam logic [5:0] EXE_SW_OP    = 6'b101011;

  // Funct (IR[5:0]) values that change sequencing
  localparam logic [5:0] EXE_JR_FUNCT = 6'b001000;

  // ALU operation request handed to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_LOGIC = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_RS     = 2'b11;

  // ALU B operand select
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       pcen;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       extop;
    logic [1:0] aluop;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  // Every R-type is legal: the funct field only chooses between JR and the
  // generic ALU path, and the ALU decoder deals with the rest.
  function automatic logic op_is_legal(logic [5:0] op);
    logic legal;
    case (op)
      EXE_RTYPE_OP, EXE_J_OP, EXE_BEQ_OP, EXE_ADDI_OP, EXE_ANDI_OP,
      EXE_ORI_OP, EXE_XORI_OP, EXE_LUI_OP, EXE_LW_OP, EXE_SW_OP: legal = 1'b1;
      default:                                                  legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_outdec.sv
// ctrl_outdec: combinational state/op -> control word decoder.
//   state_i   : current FSM state
//   op_i      : IR opcode (selects IMMEXE ALU mode, flags illegal in DECODE)
//   zero_i    : ALU zero flag (branch resolution)
//   mem_ready_i : memory handshake completion, qualifies FETCH/MEMWR strobes
//   ctrl_o    : full control word; everything not named below is 0
module ctrl_outdec
  import multicycle_ctrl_pkg::*;
(
  input  state_t     state_i,
  input  logic [5:0] op_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  logic pcwrite;
  logic branch;

  always_comb begin
    ctrl_o  = '0;
    pcwrite = 1'b0;
    branch  = 1'b0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_req = 1'b1;
        ctrl_o.iord    = 1'b0;
        ctrl_o.alusrca = 1'b0;
        ctrl_o.alusrcb = SRCB_FOUR;
        ctrl_o.aluop   = ALUOP_ADD;
        ctrl_o.pcsrc   = PCSRC_ALU;
        // IR and PC only move once the instruction word is actually there.
        if (mem_ready_i) begin
          ctrl_o.irwrite = 1'b1;
          pcwrite        = 1'b1;
        end
      end
      S_DECODE: begin
        // Branch target computed speculatively into ALUOut.
        ctrl_o.alusrca = 1'b0;
        ctrl_o.alusrcb = SRCB_IMMSH;
        ctrl_o.extop   = 1'b0;
        ctrl_o.aluop   = ALUOP_ADD;
        if (!op_is_legal(op_i)) begin
          ctrl_o.illegal_op = 1'b1;
          ctrl_o.instr_done = 1'b1;
        end
      end
      S_MEMADR: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_IMM;
        ctrl_o.extop   = 1'b0;
        ctrl_o.aluop   = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl_o.mem_req = 1'b1;
        ctrl_o.iord    = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.regwrite   = 1'b1;
        ctrl_o.regdst     = 1'b0;
        ctrl_o.memtoreg   = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.mem_req    = 1'b1;
        ctrl_o.iord       = 1'b1;
        ctrl_o.memwrite   = 1'b1;
        ctrl_o.instr_done = mem_ready_i;
      end
      S_RTEXE: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_B;
        ctrl_o.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl_o.regwrite   = 1'b1;
        ctrl_o.regdst     = 1'b1;
        ctrl_o.memtoreg   = 1'b0;
        ctrl_o.instr_done = 1'b1;
      end
      S_BEQ: begin
        ctrl_o.alusrca    = 1'b1;
        ctrl_o.alusrcb    = SRCB_B;
        ctrl_o.aluop      = ALUOP_SUB;
        ctrl_o.pcsrc      = PCSRC_ALUOUT;
        branch            = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_IMMEXE: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_IMM;
        // ADDI sign-extends and adds; the logical immediates and LUI
        // zero-extend and let the ALU decoder pick the op from the opcode.
        if (op_i == EXE_ADDI_OP) begin
          ctrl_o.aluop = ALUOP_ADD;
          ctrl_o.extop = 1'b0;
        end else begin
          ctrl_o.aluop = ALUOP_LOGIC;
          ctrl_o.extop = 1'b1;
        end
      end
      S_IMMWB: begin
        ctrl_o.regwrite   = 1'b1;
        ctrl_o.regdst     = 1'b0;
        ctrl_o.memtoreg   = 1'b0;
        ctrl_o.instr_done = 1'b1;
      end
      S_JUMP: begin
        pcwrite           = 1'b1;
        ctrl_o.pcsrc      = PCSRC_JUMP;
        ctrl_o.instr_done = 1'b1;
      end
      S_JR: begin
        pcwrite           = 1'b1;
        ctrl_o.pcsrc      = PCSRC_RS;
        ctrl_o.instr_done = 1'b1;
      end
      default: ; // IDLE and unused encodings: all zero
    endcase
    ctrl_o.pcen = pcwrite | (branch & zero_i);
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore-style sequencer for a shared-memory multi-cycle
// MIPS datapath.
//   clk, rst (async, active low)
//   op, funct, zero, mem_ready        : datapath / memory status inputs
//   mem_req, iord, memwrite           : memory port control
//   irwrite, pcen, pcsrc              : IR / PC update
//   alusrca, alusrcb, extop, aluop    : ALU operand and mode selects
//   regdst, memtoreg, regwrite        : register file write-back
//   instr_done, illegal_op            : per-instruction status pulses
//   state_o                           : current state (debug)
//
// Memory handshake: mem_req is held high, together with every address and
// select output, for as long as the FSM sits in a memory state; the access
// completes in the cycle where mem_req and mem_ready are both high, and the
// FSM only advances on that cycle.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               iord,
  output logic               memwrite,
  output logic               irwrite,
  output logic               pcen,
  output logic [1:0]         pcsrc,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic               extop,
  output logic [1:0]         aluop,
  output logic               regdst,
  output logic               memtoreg,
  output logic               regwrite,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_o
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          EXE_RTYPE_OP: state_d = (funct == EXE_JR_FUNCT) ? S_JR : S_RTEXE;
          EXE_LW_OP,
          EXE_SW_OP:    state_d = S_MEMADR;
          EXE_BEQ_OP:   state_d = S_BEQ;
          EXE_ADDI_OP, EXE_ANDI_OP, EXE_ORI_OP,
          EXE_XORI_OP, EXE_LUI_OP: state_d = S_IMMEXE;
          EXE_J_OP:     state_d = S_JUMP;
          default:      state_d = S_FETCH; // illegal: flagged by decoder
        endcase
      end
      S_MEMADR: state_d = (op == EXE_SW_OP) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_RTEXE:  state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BEQ:    state_d = S_FETCH;
      S_IMMEXE: state_d = S_IMMWB;
      S_IMMWB:  state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_JR:     state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  ctrl_outdec u_outdec (
    .state_i     (state_q),
    .op_i        (op),
    .zero_i      (zero),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl)
  );

  assign mem_req    = ctrl.mem_req;
  assign iord       = ctrl.iord;
  assign memwrite   = ctrl.memwrite;
  assign irwrite    = ctrl.irwrite;
  assign pcen       = ctrl.pcen;
  assign pcsrc      = ctrl.pcsrc;
  assign alusrca    = ctrl.alusrca;
  assign alusrcb    = ctrl.alusrcb;
  assign extop      = ctrl.extop;
  assign aluop      = ctrl.aluop;
  assign regdst     = ctrl.regdst;
  assign memtoreg   = ctrl.memtoreg;
  assign regwrite   = ctrl.regwrite;
  assign instr_done = ctrl.instr_done;
  assign illegal_op = ctrl.illegal_op;
  assign state_o    = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: directed instruction sequence with an
// expected-state queue filled per instruction and drained cycle by cycle.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic       mem_req, iord, memwrite, irwrite, pcen;
  logic [1:0] pcsrc, alusrcb, aluop;
  logic       alusrca, extop, regdst, memtoreg, regwrite, instr_done, illegal_op;
  logic [3:0] state_o;
  logic [17:0] all_out;

  assign all_out = {mem_req, iord, memwrite, irwrite, pcen, pcsrc, alusrca,
                    alusrcb, extop, aluop, regdst, memtoreg, regwrite,
                    instr_done, illegal_op};

  multicycle_ctrl #(.STATE_W(4)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .iord(iord),
    .memwrite(memwrite), .irwrite(irwrite), .pcen(pcen), .pcsrc(pcsrc),
    .alusrca(alusrca), .alusrcb(alusrcb), .extop(extop), .aluop(aluop),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
    .instr_done(instr_done), .illegal_op(illegal_op), .state_o(state_o)
  );

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  int done_cnt;
  logic [3:0] exp_q[$];

  logic [5:0] ops_tbl [6] = '{6'b100011, 6'b101011, 6'b000000,
                              6'b000100, 6'b001110, 6'b000010};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected state walk for one instruction, from FETCH to its last state.
  function automatic void push_path(input logic [5:0] o, input logic [5:0] f);
    exp_q.push_back(4'd1);
    exp_q.push_back(4'd2);
    case (o)
      6'b100011: begin exp_q.push_back(4'd3); exp_q.push_back(4'd4); exp_q.push_back(4'd5); end
      6'b101011: begin exp_q.push_back(4'd3); exp_q.push_back(4'd6); end
      6'b000000: begin
        if (f == 6'b001000) exp_q.push_back(4'd13);
        else begin exp_q.push_back(4'd7); exp_q.push_back(4'd8); end
      end
      6'b000100: exp_q.push_back(4'd9);
      6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001111: begin
        exp_q.push_back(4'd10); exp_q.push_back(4'd11);
      end
      6'b000010: exp_q.push_back(4'd12);
      default: ; // illegal: FETCH, DECODE only
    endcase
  endfunction

  // Per-state control checks; last marks the final cycle of the instruction.
  task automatic chk_state_outputs(input logic [3:0] e, input logic [5:0] o,
                                   input logic z, input logic last);
    case (e)
      4'd1: chk("fetch_ctl", {mem_req, iord, irwrite, pcen, alusrca, alusrcb, aluop, pcsrc},
                {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00});
      4'd2: begin
        chk("decode_srcb", {alusrca, alusrcb, extop, aluop}, {1'b0, 2'b11, 1'b0, 2'b00});
        chk("illegal_op", illegal_op, last);
      end
      4'd3: chk("memadr_ctl", {alusrca, alusrcb, aluop}, {1'b1, 2'b10, 2'b00});
      4'd4: chk("memrd_ctl", {mem_req, iord, memwrite}, {1'b1, 1'b1, 1'b0});
      4'd5: chk("memwb_ctl", {regdst, memtoreg}, {1'b0, 1'b1});
      4'd6: chk("memwr_ctl", {mem_req, iord, memwrite}, {1'b1, 1'b1, 1'b1});
      4'd7: chk("rtexe_ctl", {alusrca, alusrcb, aluop}, {1'b1, 2'b00, 2'b10});
      4'd8: chk("aluwb_ctl", {regdst, memtoreg}, {1'b1, 1'b0});
      4'd9: chk("beq_ctl", {pcen, pcsrc, aluop, alusrca}, {z, 2'b01, 2'b01, 1'b1});
      4'd10: chk("immexe_ctl", {alusrca, alusrcb, aluop, extop},
                 (o == 6'b001000) ? {1'b1, 2'b10, 2'b00, 1'b0} : {1'b1, 2'b10, 2'b11, 1'b1});
      4'd11: chk("immwb_ctl", {regdst, memtoreg}, {1'b0, 1'b0});
      4'd12: chk("jump_ctl", {pcen, pcsrc}, {1'b1, 2'b10});
      4'd13: chk("jr_ctl", {pcen, pcsrc}, {1'b1, 2'b11});
      default: ;
    endcase
  endtask

  // ---------------- driver ----------------
  // Runs one instruction starting in FETCH; waits stalls the memory
  // data-phase state (MEMRD/MEMWR) for that many cycles.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                           input logic z, input int waits);
    int wait_left;
    int budget;
    logic [3:0] e;
    logic last;
    logic exp_rw;
    wait_left = waits;
    budget = 0;
    op = o; funct = f; zero = z; done_cnt = 0;
    push_path(o, f);
    while (exp_q.size() > 0 && budget < 50) begin
      budget++;
      e = exp_q[0];
      if ((e == 4'd4 || e == 4'd6) && wait_left > 0) begin
        mem_ready = 1'b0;
        #1;
        chk("wait_state", state_o, e);
        chk("wait_hold", {mem_req, iord, memwrite}, {1'b1, 1'b1, (e == 4'd6)});
        chk("wait_no_done", {instr_done, regwrite}, 2'b00);
        wait_left--;
      end else begin
        e = exp_q.pop_front();
        mem_ready = 1'b1;
        #1;
        last = (exp_q.size() == 0);
        exp_rw = (e == 4'd5) || (e == 4'd8) || (e == 4'd11);
        chk("state", state_o, e);
        chk("instr_done", instr_done, last);
        chk("regwrite", regwrite, exp_rw);
        chk("memwrite", memwrite, (e == 4'd6));
        chk_state_outputs(e, o, z, last);
        if (instr_done) done_cnt++;
      end
      step();
    end
    chk("cycle_budget", exp_q.size(), 0);
    exp_q.delete();
    mem_ready = 1'b1;
    #1;
    chk("back_to_fetch", state_o, 4'd1);
    chk("done_pulses", done_cnt, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    op = 6'b100011; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", state_o, 4'd0);
    chk("reset_outputs", all_out, 18'd0);
    rst = 1'b1;
    #1;
    chk("idle_state", state_o, 4'd0);
    chk("idle_outputs", all_out, 18'd0);
    step();

    run_instr(6'b100011, 6'd0, 1'b0, 0);        // LW
    run_instr(6'b101011, 6'd0, 1'b0, 3);        // SW, 3 wait cycles
    run_instr(6'b000100, 6'd0, 1'b1, 0);        // BEQ taken
    run_instr(6'b000100, 6'd0, 1'b0, 0);        // BEQ not taken
    run_instr(6'b001101, 6'd0, 1'b0, 0);        // ORI
    run_instr(6'b001000, 6'd0, 1'b0, 0);        // ADDI
    run_instr(6'b001111, 6'd0, 1'b0, 0);        // LUI
    run_instr(6'b000000, 6'b100000, 1'b0, 0);   // ADD (R-type)
    run_instr(6'b000000, 6'b001000, 1'b0, 0);   // JR
    run_instr(6'b000010, 6'd0, 1'b0, 0);        // J
    run_instr(6'b111111, 6'd0, 1'b0, 0);        // illegal
    run_instr(6'b100011, 6'd0, 1'b0, 2);        // LW with read wait

    for (int i = 0; i < 8; i++) begin
      int idx;
      idx = $urandom_range(0, 5);
      run_instr(ops_tbl[idx], 6'b100010, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    // Reset while MEMRD is stalled.
    op = 6'b100011; funct = 6'd0; mem_ready = 1'b1;
    #1; chk("mid_fetch", state_o, 4'd1);
    step();
    #1; chk("mid_decode", state_o, 4'd2);
    step();
    #1; chk("mid_memadr", state_o, 4'd3);
    step();
    mem_ready = 1'b0;
    #1; chk("mid_memrd", {state_o, mem_req}, {4'd4, 1'b1});
    rst = 1'b0;
    #1;
    chk("async_reset_state", state_o, 4'd0);
    chk("async_reset_outputs", all_out, 18'd0);
    step();
    chk("reset_hold_state", state_o, 4'd0);
    chk("reset_hold_outputs", all_out, 18'd0);
    rst = 1'b1;
    #1;
    chk("post_reset_idle", state_o, 4'd0);
    step();
    run_instr(6'b000010, 6'd0, 1'b0, 0);        // J after reset

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
